ro_reader: RTL and testbench
============================

# ro_reader

Consumer side of the ring-oscillator entropy path. Accepts the raw 1-bit XOR stream produced by the RO sampler and checks it with a repetition-count health test. It optionally debiases the stream (von Neumann), packs the bits into bytes and buffers them in a small FIFO. The host pops bytes with a single-cycle read handshake, which replaces the fixed byte-select window with a lossless, ordered byte stream.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte entries; power of two, at least 2
- REP_LIMIT, 32, consecutive identical raw bits that trigger a health failure; range 2..255

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  collection enable
- bit_in  in  1  raw entropy bit
- bit_valid  in  1  bit_in qualifier; one bit per asserted cycle
- rd_en  in  1  pop request
- clr_flags  in  1  clears rep_fail and overflow
- data_out  out  8  popped byte, registered
- data_valid  out  1  high for one cycle when data_out was updated by a pop
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- empty  out  1  level == 0
- full  out  1  level == FIFO_DEPTH
- rep_fail  out  1  sticky health-test failure
- overflow  out  1  sticky; a completed byte was dropped

## Operation
- **Accept:** a raw bit is accepted when enable && bit_valid.
- **Health test** (raw accepted bits, before debiasing):
  - rep_cnt (8 bits) resets to 1 when an accepted bit differs from the previous one; otherwise it increments and saturates at REP_LIMIT.
  - When rep_cnt reaches REP_LIMIT, rep_fail is set.
  - The first accepted bit after reset or clr_flags starts rep_cnt at 1.
- **Debias FSM** (only with the macro), states PAIR_A and PAIR_B:
  - PAIR_A: an accepted bit is latched as first and the FSM moves to PAIR_B.
  - PAIR_B: an accepted bit resolves the pair and the FSM returns to PAIR_A.
  - Pair 10 emits 1, pair 01 emits 0, pairs 00 and 11 emit nothing.
- **Packer:**
  - Each emitted bit shifts in as pack <= {pack[6:0], bit}, so the first bit lands in bit 7.
  - A 3-bit count tracks bits collected; the 8th bit completes the byte.
- **Push:** a completed byte is written to the FIFO if !full or if a pop happens in the same cycle. Otherwise the byte is dropped, overflow is set and the packer restarts.
- **rep_fail set:**
  - Packer, debias FSM and count are held cleared; no pushes.
  - rep_cnt keeps running.
  - Reads remain allowed.
- **enable low:**
  - Packer, FSM and bit count are cleared; a partial byte is discarded.
  - rep_cnt and the previous-bit register are cleared.
  - FIFO contents are retained.
- **Pop:** rd_en && !empty loads the FIFO head into data_out and pulses data_valid.
  - rd_en while empty is ignored: data_valid stays 0 and data_out holds.
- **Simultaneous push and pop:**
  - Both take effect and level is unchanged.
  - When empty, a same-cycle push is not poppable.
- **clr_flags:**
  - Clears rep_fail, overflow and rep_cnt in that cycle.
  - Takes priority over a same-cycle set.

## Timing
- Reset values:
  - data_out = 0x00, data_valid = 0, level = 0, empty = 1, full = 0, rep_fail = 0, overflow = 0.
  - FSM = PAIR_A, packer and counters = 0.
- Completing bit sampled at edge N: level, empty and full reflect the push after edge N.
- Pop sampled at edge N: data_out and data_valid valid after edge N (1-cycle latency); data_valid is low after edge N+1 unless rd_en is still high with data available.
- rep_fail and overflow assert after the edge that samples the triggering bit.
- Pushes are blocked from that same edge onward.
- Back-to-back pops sustain one byte per cycle.
- rst_n low at any time clears all state immediately, including mid-byte and mid-pair state.

## Configuration
- Macro: RO_READER_VN_DEBIAS_EN.
- **Defined:** the von Neumann FSM is present; at most one emitted bit per two accepted raw bits.
- **Undefined:** the FSM is absent and every accepted raw bit goes straight to the packer.
- The health test is present in both builds.

## Structure
- Package ro_pkg holds:
  - RO_BYTE_W = 8;
  - the debias state enum (PAIR_A, PAIR_B);
  - the default FIFO_DEPTH and REP_LIMIT constants, shared with the sampler side.
- Sub-module ro_fifo:
  - synchronous FIFO with parameterized depth, read/write pointers one bit wider than the address, level output;
  - write and read enables are gated by ro_reader.

## Test plan
- **Packing, macro undefined:** accepted bits 1,0,1,0,0,1,0,1 -> level 1; pop -> data_out 0xA5 with a one-cycle data_valid.
- **Debiasing, macro defined:** raw pairs 10,00,01,10,11,01,01,10,01,10 -> byte 0xA5 pushed after the 20th raw bit.
  - The 00 and 11 pairs are dropped.
  - level stays 0 before the 20th raw bit.
- **Repetition test:** REP_LIMIT = 32; thirty-one 1s -> rep_fail 0; 32nd 1 -> rep_fail 1 and no further pushes.
  - clr_flags -> rep_fail 0 and collection resumes.
- **Overflow:** FIFO_DEPTH = 4 with 5 bytes pushed and no pops -> full = 1, overflow = 1.
  - Four pops return bytes 1-4 in order, then empty = 1.
  - A 5th pop yields data_valid 0.
- **Full with simultaneous events and reset:** on a full FIFO, push and pop in the same cycle -> level stays 4 and no overflow.
  - Assert rst_n low mid-byte (3 bits packed) -> all outputs return to reset values.
  - After release, 8 new bits form a clean byte.

Source files
------------

// File: rtl/ro_pkg.sv
// Shared constants and types for the ring-oscillator entropy path.
// The defaults are common to the sampler side and to ro_reader.
package ro_pkg;

    localparam int RO_BYTE_W             = 8;
    localparam int RO_FIFO_DEPTH_DEFAULT = 4;
    localparam int RO_REP_LIMIT_DEFAULT  = 32;

    // Von Neumann pair tracker: waiting for the first or the second bit of a pair
    typedef enum logic {
        PAIR_A = 1'b0,
        PAIR_B = 1'b1
    } vn_state_t;

endpackage

// File: rtl/ro_fifo.sv
// Small synchronous byte FIFO with a registered read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Callers must gate wr_en/rd_en against full/empty themselves.
module ro_fifo
    import ro_pkg::*;
#(
    parameter int DEPTH = RO_FIFO_DEPTH_DEFAULT,
    parameter int W     = RO_BYTE_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level
);

    logic [W-1:0] mem_reg [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] rd_data_reg;

    // Storage array, left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; a simultaneous read and write leaves the level unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Registered read: the head is captured only on a pop, otherwise the output holds.
    // On a full FIFO with a same-cycle write, the old head is read before being overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_ptr_reg[AW-1:0]];
        end
    end

    assign rd_data = rd_data_reg;
    assign level   = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/ro_reader.sv
// Consumer of the raw ring-oscillator bit stream: repetition-count health
// test, optional von Neumann debiasing, byte packing and a byte FIFO that
// the host drains with a single-cycle pop handshake.
// Build option: define RO_READER_VN_DEBIAS_EN to insert the von Neumann debiaser.
module ro_reader
    import ro_pkg::*;
#(
    parameter int FIFO_DEPTH = RO_FIFO_DEPTH_DEFAULT,
    parameter int REP_LIMIT  = RO_REP_LIMIT_DEFAULT,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  rd_en,
    input  logic                  clr_flags,
    output logic [RO_BYTE_W-1:0]  data_out,
    output logic                  data_valid,
    output logic [LW-1:0]         level,
    output logic                  empty,
    output logic                  full,
    output logic                  rep_fail,
    output logic                  overflow
);

    localparam logic [7:0] REP_LIMIT_C = 8'(REP_LIMIT);

    logic                 accept;
    logic [7:0]           rep_cnt_reg;
    logic [7:0]           rep_cnt_next;
    logic                 prev_bit_reg;
    logic                 have_prev_reg;
    logic                 rep_hit;
    logic                 rep_fail_reg;
    logic                 overflow_reg;
    logic                 collect_ok;
    logic                 emit;
    logic                 emit_bit;
    logic [RO_BYTE_W-1:0] pack_reg;
    logic [2:0]           bit_cnt_reg;
    logic                 byte_done;
    logic [RO_BYTE_W-1:0] byte_word;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 data_valid_reg;

    assign accept = enable && bit_valid;

    // Run length of the current raw bit value, saturating at the limit
    always_comb begin
        rep_cnt_next = 8'd1;
        if (have_prev_reg && (bit_in == prev_bit_reg)) begin
            rep_cnt_next = (rep_cnt_reg < REP_LIMIT_C) ? rep_cnt_reg + 8'd1 : REP_LIMIT_C;
        end
    end

    assign rep_hit = accept && (rep_cnt_next == REP_LIMIT_C);

    // Health-test history; clearing forgets the previous bit so the next one restarts the run at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_reg   <= 8'd0;
            prev_bit_reg  <= 1'b0;
            have_prev_reg <= 1'b0;
        end else if (clr_flags || !enable) begin
            rep_cnt_reg   <= 8'd0;
            prev_bit_reg  <= 1'b0;
            have_prev_reg <= 1'b0;
        end else if (accept) begin
            rep_cnt_reg   <= rep_cnt_next;
            prev_bit_reg  <= bit_in;
            have_prev_reg <= 1'b1;
        end
    end

    // Collection stops on the very bit that trips the health test
    assign collect_ok = enable && !rep_fail_reg && !rep_hit;

`ifdef RO_READER_VN_DEBIAS_EN
    vn_state_t state_reg;
    vn_state_t state_next;
    logic      first_reg;
    logic      first_next;

    // Debias state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PAIR_A;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= first_next;
        end
    end

    // Pair resolution: 10 emits 1, 01 emits 0, equal pairs emit nothing
    always_comb begin
        state_next = state_reg;
        first_next = first_reg;
        emit       = 1'b0;
        emit_bit   = first_reg;
        if (!collect_ok) begin
            state_next = PAIR_A;
            first_next = 1'b0;
        end else if (accept) begin
            case (state_reg)
                PAIR_A: begin
                    first_next = bit_in;
                    state_next = PAIR_B;
                end
                PAIR_B: begin
                    state_next = PAIR_A;
                    emit       = (first_reg != bit_in);
                end
                default: state_next = PAIR_A;
            endcase
        end
    end
`else
    assign emit     = accept && collect_ok;
    assign emit_bit = bit_in;
`endif

    // The 8th emitted bit completes a byte; the first bit ends up in the MSB
    assign byte_done = emit && (bit_cnt_reg == 3'd7);
    assign byte_word = {pack_reg[RO_BYTE_W-2:0], emit_bit};

    assign pop  = rd_en && !empty;
    assign push = byte_done && (!full || pop);
    assign drop = byte_done && !push;

    // Shift register and bit count; the count wraps to 0 after a completed (or dropped) byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg    <= '0;
            bit_cnt_reg <= 3'd0;
        end else if (!collect_ok) begin
            pack_reg    <= '0;
            bit_cnt_reg <= 3'd0;
        end else if (emit) begin
            pack_reg    <= byte_word;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    // Sticky status flags; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_fail_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (clr_flags) begin
            rep_fail_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (rep_hit) rep_fail_reg <= 1'b1;
            if (drop)    overflow_reg <= 1'b1;
        end
    end

    // One-cycle strobe marking that data_out was refreshed by a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= pop;
        end
    end

    ro_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (RO_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (byte_word),
        .rd_en   (pop),
        .rd_data (data_out),
        .level   (level)
    );

    assign empty      = (level == '0);
    assign full       = (level == LW'(FIFO_DEPTH));
    assign data_valid = data_valid_reg;
    assign rep_fail   = rep_fail_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ro_reader.sv
// Self-checking bench for ro_reader (default parameters). Honours
// RO_READER_VN_DEBIAS_EN so the same bench covers both builds.
module tb_ro_reader;

    localparam int DEPTH = 4;
    localparam int LIMIT = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] level;
    logic       empty;
    logic       full;
    logic       rep_fail;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: byte queue plus bit-level bookkeeping
    logic [7:0] m_q[$];
    logic [7:0] m_acc;
    int         m_nbits;
    bit         m_have_prev;
    bit         m_prev;
    int         m_run;
    bit         m_fail;
    bit         m_ovf;
    bit         m_half;
    bit         m_first;
    logic [7:0] m_dout;
    bit         m_dv;

    ro_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .rd_en      (rd_en),
        .clr_flags  (clr_flags),
        .data_out   (data_out),
        .data_valid (data_valid),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .rep_fail   (rep_fail),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_q.delete();
        m_acc = 8'h00; m_nbits = 0;
        m_have_prev = 0; m_prev = 0; m_run = 0;
        m_fail = 0; m_ovf = 0; m_half = 0; m_first = 0;
        m_dout = 8'h00; m_dv = 0;
    endfunction

    function automatic void model_clear_collect();
        m_acc = 8'h00; m_nbits = 0; m_half = 0;
    endfunction

    function automatic void model_emit(bit e);
        m_acc = {m_acc[6:0], e};
        m_nbits++;
        if (m_nbits == 8) begin
            m_nbits = 0;
            if (m_q.size() < DEPTH) m_q.push_back(m_acc);
            else m_ovf = 1;
        end
    endfunction

    function automatic void model_cycle(bit e, bit v, bit b, bit r, bit c);
        bit hit;
        hit = 0;
        if (r && m_q.size() > 0) begin
            m_dout = m_q.pop_front();
            m_dv = 1;
        end else begin
            m_dv = 0;
        end
        if (!e) begin
            model_clear_collect();
            m_have_prev = 0;
            m_run = 0;
        end else if (v) begin
            if (m_have_prev && b == m_prev) m_run = (m_run < LIMIT) ? m_run + 1 : LIMIT;
            else m_run = 1;
            m_prev = b;
            m_have_prev = 1;
            hit = (m_run == LIMIT);
            if (m_fail || hit) begin
                model_clear_collect();
            end else begin
`ifdef RO_READER_VN_DEBIAS_EN
                if (!m_half) begin
                    m_first = b;
                    m_half = 1;
                end else begin
                    m_half = 0;
                    if (m_first != b) model_emit(m_first);
                end
`else
                model_emit(b);
`endif
            end
            if (hit) m_fail = 1;
        end
        if (c) begin
            m_fail = 0; m_ovf = 0; m_run = 0; m_have_prev = 0;
        end
    endfunction

    task automatic step(input bit e, input bit v, input bit b, input bit r, input bit c);
        enable = e; bit_valid = v; bit_in = b; rd_en = r; clr_flags = c;
        model_cycle(e, v, b, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        step(1, 1, b, 0, 0);
    endtask

    // Sends one byte MSB first; the debias build encodes each bit as a pair
    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) begin
`ifdef RO_READER_VN_DEBIAS_EN
            send_bit(x[i]);
            send_bit(!x[i]);
`else
            send_bit(x[i]);
`endif
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 16) begin
            step(1, 0, 0, 1, 0);
            checks++;
            if (data_valid !== 1'b1 || data_out !== m_dout) begin
                errors++;
                $display("FAIL drain_pop: data_valid=%0b data_out=%02h, required 1 / %02h", data_valid, data_out, m_dout);
            end
            guard++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({data_out, data_valid, level, empty, full, rep_fail, overflow} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: dout=%02h dv=%0b lvl=%0d empty=%0b full=%0b rep=%0b ovf=%0b, required 00 0 0 1 0 0 0",
                     data_out, data_valid, level, empty, full, rep_fail, overflow);
        end
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        checks++;
        if (level !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: level=%0d empty=%0b, required 0 1", level, empty);
        end
    endtask

`ifdef RO_READER_VN_DEBIAS_EN
    task automatic test_debias();
        bit pat [20] = '{1,0, 0,0, 0,1, 1,0, 1,1, 0,1, 0,1, 1,0, 0,1, 1,0};
        for (int i = 0; i < 19; i++) send_bit(pat[i]);
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL debias_early: level=%0d, required 0", level);
        end
        send_bit(pat[19]);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL debias_push: level=%0d, required 1", level);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL debias_pop: data_out=%02h dv=%0b, required a5 1", data_out, data_valid);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL debias_dv_pulse: dv=%0b, required 0", data_valid);
        end
    endtask
`else
    task automatic test_pack();
        bit pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL pack_early: level=%0d, required 0", level);
        end
        send_bit(pat[7]);
        checks++;
        if (level !== 3'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL pack_push: level=%0d empty=%0b, required 1 0", level, empty);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_out !== 8'hA5 || data_valid !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL pack_pop: data_out=%02h dv=%0b level=%0d, required a5 1 0", data_out, data_valid, level);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL pop_empty: dv=%0b data_out=%02h, required 0 a5", data_valid, data_out);
        end
    endtask
`endif

    task automatic test_rep();
        int lvl_at_fail;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) send_bit(1'b1);
        checks++;
        if (rep_fail !== 1'b0) begin
            errors++;
            $display("FAIL rep_31: rep_fail=%0b, required 0", rep_fail);
        end
        send_bit(1'b1);
        checks++;
        if (rep_fail !== 1'b1 || level !== 3'(m_q.size())) begin
            errors++;
            $display("FAIL rep_32: rep_fail=%0b level=%0d, required 1 %0d", rep_fail, level, m_q.size());
        end
        lvl_at_fail = m_q.size();
        for (int i = 0; i < 16; i++) send_bit(i[0]);
        checks++;
        if (level !== 3'(lvl_at_fail) || rep_fail !== 1'b1) begin
            errors++;
            $display("FAIL rep_blocked: level=%0d rep_fail=%0b, required %0d 1", level, rep_fail, lvl_at_fail);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (rep_fail !== 1'b0) begin
            errors++;
            $display("FAIL rep_clear: rep_fail=%0b, required 0", rep_fail);
        end
        drain();
        send_byte(8'h3C);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL rep_resume: level=%0d, required 1", level);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_out !== 8'h3C || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL rep_resume_data: data_out=%02h dv=%0b, required 3c 1", data_out, data_valid);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) send_byte(8'(k));
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_state: full=%0b overflow=%0b level=%0d, required 1 1 4", full, overflow, level);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 1, 0);
            checks++;
            if (data_out !== 8'(k) || data_valid !== 1'b1) begin
                errors++;
                $display("FAIL ovf_pop%0d: data_out=%02h dv=%0b, required %02h 1", k, data_out, data_valid, k);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: empty=%0b, required 1", empty);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_valid !== 1'b0 || data_out !== 8'h04) begin
            errors++;
            $display("FAIL ovf_pop5: dv=%0b data_out=%02h, required 0 04", data_valid, data_out);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%0b, required 0", overflow);
        end
    endtask

    task automatic test_full_simul();
        logic [7:0] nb;
        nb = 8'h66;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        for (int i = 7; i >= 1; i--) begin
`ifdef RO_READER_VN_DEBIAS_EN
            send_bit(nb[i]); send_bit(!nb[i]);
`else
            send_bit(nb[i]);
`endif
        end
`ifdef RO_READER_VN_DEBIAS_EN
        send_bit(nb[0]);
        step(1, 1, !nb[0], 1, 0);
`else
        step(1, 1, nb[0], 1, 0);
`endif
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0 || data_out !== 8'h11 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovf=%0b dout=%02h dv=%0b, required 4 0 11 1", level, overflow, data_out, data_valid);
        end
        // Three bits into a new byte, then an asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
`ifdef RO_READER_VN_DEBIAS_EN
            send_bit(!i[0]); send_bit(i[0]);
`else
            send_bit(!i[0]);
`endif
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, level, empty, full, rep_fail, overflow} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: dout=%02h dv=%0b lvl=%0d empty=%0b full=%0b rep=%0b ovf=%0b, required 00 0 0 1 0 0 0",
                     data_out, data_valid, level, empty, full, rep_fail, overflow);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_byte(8'h5A);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_level: level=%0d, required 1", level);
        end
        step(1, 0, 0, 1, 0);
        checks++;
        if (data_out !== 8'h5A || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_byte: data_out=%02h dv=%0b, required 5a 1", data_out, data_valid);
        end
    endtask

    task automatic test_random();
        bit e, v, b, r, c;
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 24) != 0);
            v = ($urandom_range(0, 3) != 0);
            b = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 4) == 0);
            c = (!v && $urandom_range(0, 39) == 0);
            step(e, v, b, r, c);
            checks++;
            if (level !== 3'(m_q.size()) || data_valid !== m_dv || (m_dv && data_out !== m_dout) ||
                rep_fail !== m_fail || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_%0d: lvl=%0d dv=%0b dout=%02h rep=%0b ovf=%0b, required %0d %0b %02h %0b %0b",
                         n, level, data_valid, data_out, rep_fail, overflow, m_q.size(), m_dv, m_dout, m_fail, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef RO_READER_VN_DEBIAS_EN
        test_debias();
`else
        test_pack();
`endif
        test_rep();
        test_overflow();
        test_full_simul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
